// File: rtl/secret_accum_bank.sv
// Bank of CHANNELS accumulators that add in_data plus a fixed secret per accepted request,
// returning the post-update value through a single output register. Define SECRET_ACCUM_SAT_EN to saturate on overflow.
module secret_accum_bank #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 4,
    parameter logic [WIDTH-1:0] SECRET_VALUE = WIDTH'(7)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(CHANNELS)-1:0] in_chan,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(CHANNELS)-1:0] out_chan,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_ovf,
    input  logic                        bypass,
    output logic [WIDTH-1:0]            bypass_out
);

    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] acc_q, acc_d;
    logic                           outValid_q, outValid_d;
    logic [CW-1:0]                  outChan_q, outChan_d;
    logic [WIDTH-1:0]               outData_q, outData_d;
    logic                           outOvf_q, outOvf_d;

    logic             accept;
    logic             inRange;
    logic [WIDTH-1:0] accCur;
    logic [WIDTH+1:0] sumWide;
    logic             sumOvf;
    logic [WIDTH-1:0] storeVal;

    assign in_ready = !outValid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign inRange  = int'(in_chan) < CHANNELS;

    // Channel select by search so an out-of-range index simply reads zero.
    always_comb begin
        accCur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(in_chan) == i) begin
                accCur = acc_q[i];
            end
        end
    end

    assign sumWide = {2'b00, accCur} + {2'b00, in_data} + {2'b00, SECRET_VALUE};
    assign sumOvf  = |sumWide[WIDTH+1:WIDTH];

`ifdef SECRET_ACCUM_SAT_EN
    assign storeVal = sumOvf ? '1 : sumWide[WIDTH-1:0];
`else
    assign storeVal = sumWide[WIDTH-1:0];
`endif

    assign bypass_out = bypass ? in_data : accCur;

    always_comb begin
        acc_d      = acc_q;
        outValid_d = outValid_q;
        outChan_d  = outChan_q;
        outData_d  = outData_q;
        outOvf_d   = outOvf_q;
        if (accept) begin
            outValid_d = 1'b1;
            outChan_d  = in_chan;
            if (!inRange) begin
                outData_d = '0;
                outOvf_d  = 1'b1;
            end else if (in_clear) begin
                outData_d = '0;
                outOvf_d  = 1'b0;
            end else begin
                outData_d = storeVal;
                outOvf_d  = sumOvf;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(in_chan) == i) begin
                    acc_d[i] = in_clear ? '0 : storeVal;
                end
            end
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            outValid_q <= 1'b0;
            outChan_q  <= '0;
            outData_q  <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            outValid_q <= outValid_d;
            outChan_q  <= outChan_d;
            outData_q  <= outData_d;
            outOvf_q   <= outOvf_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_chan  = outChan_q;
    assign out_data  = outData_q;
    assign out_ovf   = outOvf_q;

endmodule

// File: doc/secret_accum_bank.md
SECRET_ACCUM_BANK -- requirements
Module: secret_accum_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, accumulator and data width in bits (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent accumulators (>=2).
REQ-003 SHALL have parameter SECRET_VALUE, default 7, WIDTH-bit constant added on every accumulate.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_chan  input  $clog2(CHANNELS)  target channel.
REQ-009 SHALL have port in_data  input  WIDTH  addend.
REQ-010 SHALL have port in_clear  input  1  zero the target channel instead of accumulating.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_chan  output  $clog2(CHANNELS)  channel of result.
REQ-014 SHALL have port out_data  output  WIDTH  post-update accumulator value.
REQ-015 SHALL have port out_ovf  output  1  update overflowed WIDTH bits.
REQ-016 SHALL have port bypass  input  1  bypass select.
REQ-017 SHALL have port bypass_out  output  WIDTH  combinational: bypass ? in_data : acc[in_chan].

Function
REQ-018 SHALL drive in_ready = !out_valid || out_ready (one-entry skid-free output register).
REQ-019 SHALL, on acceptance without in_clear, set acc[in_chan] = acc[in_chan] + in_data + SECRET_VALUE, sum computed at WIDTH+2 bits.
REQ-020 SHALL, on acceptance with in_clear, set acc[in_chan] = 0, out_data 0, out_ovf 0; in_data ignored (clear wins).
REQ-021 SHALL load out_chan/out_data/out_ovf and set out_valid on the edge of acceptance: latency one cycle.
REQ-022 SHALL hold out_chan/out_data/out_ovf stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on the edge where out_valid && out_ready && !(in_valid && in_ready).
REQ-024 SHALL, on simultaneous consume and accept, replace the result with the new one with no bubble.
REQ-025 SHALL set out_ovf when the WIDTH+2-bit sum exceeds 2^WIDTH-1.
REQ-026 SHALL leave non-targeted channels unchanged on every cycle.
REQ-027 SHALL, for in_chan >= CHANNELS, accept the request, update no accumulator, return out_data 0, out_ovf 1.
REQ-028 SHALL make bypass_out read acc state before any same-cycle update (pre-edge value); out-of-range in_chan reads 0.

Reset
REQ-029 SHALL, while rst_n low, force all acc[] = 0, out_valid = 0, out_chan = 0, out_data = 0, out_ovf = 0, asynchronously.
REQ-030 SHALL drop any pending result on reset mid-operation; no acceptance on the first edge is lost after rst_n rises.

Configuration
REQ-031 SHALL support macro SECRET_ACCUM_SAT_EN: defined -> overflowing sum stores all-ones (saturate); undefined -> sum stores low WIDTH bits (wrap); out_ovf identical in both.

Verification
REQ-032 Reset, chan0 data 5 accepted -> next cycle out_valid=1, out_chan=0, out_data=12, out_ovf=0.
REQ-033 out_ready=0, two chan0 data 5 requests -> in_ready=0 after first, out_data held 12; out_ready=1 -> second yields 24.
REQ-034 chan1 data 0xFFFFFFF0 twice -> 0xFFFFFFF7, then 0xFFFFFFEE ovf=1 (wrap) or 0xFFFFFFFF ovf=1 (SECRET_ACCUM_SAT_EN).
REQ-035 chan2 at 12, in_clear=1 data 9 -> out_data 0; following chan2 data 1 -> 8; chan0/1/3 unchanged.
REQ-036 rst_n low mid-stream while out_valid=1 -> out_valid 0 immediately, bypass_out for chan0 reads 0.
REQ-037 chan0 at 12, bypass=1 in_data 0x55 -> bypass_out 0x55 same cycle; bypass=0 in_chan 0 -> 12.
